dac_cmd_sched: RTL and testbench
================================

# dac_cmd_sched

Upstream scheduler for `dac_ctrl`. It holds an 8-channel × 14-bit shadow register bank written by the host register interface. On a commit, or on a periodic refresh, it loads the requested channels into the `dac_val` bus. It then runs a four-phase request/acknowledge handshake with `dac_ctrl` through `dac_req`/`dac_ack`, and serialises and merges overlapping commits.

## Interface
- `DATA_W`, 14: DAC code width per channel. `dac_val` width is 8×`DATA_W`.
- `ACK_TIMEOUT`, 1024: maximum cycles spent in REQ or REL before the handshake is abandoned.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: write the shadow register selected by `wr_ch`. Always accepted.
- `wr_ch` in 3: shadow channel index, 0..7.
- `wr_data` in `DATA_W`: shadow value.
- `commit` in 1: single-cycle strobe that requests an update of the channels in `commit_mask`.
- `commit_mask` in 8: channel select. Bit k = channel k. Bits 3:0 = X group, bits 7:4 = Y group.
- `reg_refresh_time` in 32: refresh period in cycles. 0 disables refresh.
- `clr_err` in 1: clears `err_timeout`.
- `dac_val` out 8×`DATA_W`: active values. Channel k occupies `[DATA_W*k+DATA_W-1 : DATA_W*k]`.
- `dac_req` out 8: request mask to `dac_ctrl`. Registered.
- `dac_ack` in 1: acknowledge from `dac_ctrl`.
- `busy` out 1: high when state≠IDLE or pend≠0.
- `err_timeout` out 1: sticky handshake-timeout flag.
- `upd_cnt` out 32: count of completed handshakes. Wraps at 2^32.

## Operation
- Shadow bank: 8×`DATA_W` registers, reset 0. Written on `wr_en`; the write is visible to the next clock's logic.
- pend (8 bits): `commit` ORs `commit_mask` into pend. A refresh tick ORs 8'hFF into pend. A commit with mask 0 has no effect.
- FSM states: IDLE, LOAD, REQ, REL.
  - IDLE → LOAD when pend≠0.
  - LOAD: for each bit set in pend, copy shadow[k] → `dac_val` channel k. Unmasked channels hold their value. Set cur_mask←pend. Clear pend; a `commit` or refresh tick in this same cycle is kept, not lost. Go to REQ.
  - REQ: `dac_req`=cur_mask. Go to REL when `dac_ack`=1.
  - REL: `dac_req`=0. Go to IDLE and increment `upd_cnt` when `dac_ack`=0.
- `dac_val` is frozen from LOAD exit until the return to IDLE. Shadow writes during this window affect only the next LOAD.
- Commits arriving while busy accumulate in pend. All of them are merged into one following handshake.
- Refresh counter:
  - Runs only in IDLE with pend=0 and `reg_refresh_time`≠0.
  - Reaches `reg_refresh_time`−1 → refresh tick, then the counter clears.
  - Also clears on any commit, on leaving IDLE, and when `reg_refresh_time`=0.
- Timeout counter:
  - Clears on entry to REQ and on entry to REL.
  - Reaching `ACK_TIMEOUT` in REQ or REL → `err_timeout`←1, `dac_req`←0, go to IDLE. `upd_cnt` is not incremented and the in-flight mask is dropped.
- `err_timeout`: set has priority over a same-cycle `clr_err`.

## Timing
- Reset values:
  - `dac_val`=0, `dac_req`=0, `busy`=0, `err_timeout`=0, `upd_cnt`=0.
  - state=IDLE, pend=0, shadow=0, all counters=0.
- Reset is asynchronous. Assertion mid-handshake drops `dac_req` immediately, with no completion.
- Latency, from idle with `commit` sampled at edge t:
  - pend≠0 after t, LOAD after t+1.
  - `dac_val` updated and `dac_req` high after t+2.
- `dac_req` falls on the first edge sampling `dac_ack`=1. Minimum high time is 1 cycle.
- Completion: `upd_cnt` increments on the edge that samples `dac_ack`=0 in REL. The next LOAD is possible on the following edge, so there is a minimum of 2 idle cycles between requests.
- `wr_en` and `commit` in the same cycle on the same channel: the LOAD uses the new value.
- `busy` rises the cycle after `commit` and falls the cycle after completion if pend=0.

## Test plan
- Single update: write ch0=0x0123, commit mask 0x01. The ack model responds 3 cycles after req and releases 2 cycles after req drops. Required: `dac_req`=0x01 at t+2, `dac_val[13:0]`=0x0123, other channels 0, `upd_cnt`=1, `busy` low afterwards.
- Serialise and merge: commit 0x0F. While in REQ, commit 0x10 and then 0x20. Required: two handshakes with masks 0x0F then 0x30, `upd_cnt`=2. Channels 6–7 unchanged.
- Write/commit collision: ch5 holds 0x0AAA. Write ch5=0x3FFF in the same cycle as commit 0x20. Required: `dac_val` channel 5 = 0x3FFF. A write of 0x1111 during REQ does not alter `dac_val`.
- Timeout: `ACK_TIMEOUT`=16, `dac_ack` tied 0, commit 0x01. Required: `dac_req` drops 16 cycles after REQ entry, `err_timeout`=1, `upd_cnt` unchanged. `clr_err` pulse → `err_timeout`=0.
- Refresh: `reg_refresh_time`=100, no commits, ack model active. Required: `dac_req`=0xFF once per refresh cycle, with exactly 100 idle counted cycles between each completion and the next tick. Setting the register to 0 stops refresh.
- Reset mid-operation: assert `rst` during REQ. Required: `dac_req`=0, `dac_val`=0, `busy`=0 immediately. After release, no request is issued without a new commit.

Source files
------------

// File: rtl/dac_cmd_sched_if.sv
// Scheduler-to-dac_ctrl link: the active value bus plus the four-phase
// request/acknowledge pair.
interface dac_cmd_sched_if #(
  parameter int DATA_W = 14
) ();
  logic [8*DATA_W-1:0] dac_val;
  logic [7:0]          dac_req;
  logic                dac_ack;

  modport master (output dac_val, output dac_req, input dac_ack);
  modport slave  (input dac_val, input dac_req, output dac_ack);
endinterface

// File: rtl/dac_cmd_sched.sv
// Shadow bank plus commit/refresh scheduler that loads dac_val and runs a
// four-phase req/ack handshake with dac_ctrl, merging commits that arrive while busy.
module dac_cmd_sched #(
  parameter int DATA_W      = 14,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_ch_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic [7:0]        commit_mask_i,
  input  logic [31:0]       reg_refresh_time_i,
  input  logic              clr_err_i,
  dac_cmd_sched_if.master   dac,
  output logic              busy_o,
  output logic              err_timeout_o,
  output logic [31:0]       upd_cnt_o
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, REQ, REL} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   shadow_q [8];
  logic [7:0]          pend_q, pend_d;
  logic [7:0]          new_bits;
  logic [31:0]         rcnt_q, rcnt_d;
  logic                refresh_run, refresh_tick;
  logic [TMO_W-1:0]    tmo_q;
  logic                tmo_hit;
  logic [8*DATA_W-1:0] dac_val_q;
  logic [7:0]          dac_req_q;
  logic                err_q;
  logic [31:0]         upd_cnt_q;

  // NOTE: the shadow bank is an array of flops, not a RAM, so it takes the
  // async reset like any other register and a fresh reset commits zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) shadow_q[k] <= '0;
    end else if (wr_en_i) begin
      shadow_q[wr_ch_i] <= wr_data_i;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on any path.
  always_comb begin
    refresh_run  = (state_q == IDLE) && (pend_q == 8'h00) && (reg_refresh_time_i != 32'd0);
    refresh_tick = refresh_run && (rcnt_q == reg_refresh_time_i - 32'd1);
    rcnt_d       = '0;
    if (refresh_run && !commit_i && !refresh_tick) rcnt_d = rcnt_q + 32'd1;
    new_bits = (commit_i ? commit_mask_i : 8'h00) | (refresh_tick ? 8'hFF : 8'h00);
    // LOAD consumes pend, but requests arriving in that very cycle survive.
    pend_d   = (state_q == LOAD) ? new_bits : (pend_q | new_bits);
    tmo_hit  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      rcnt_q    <= '0;
      tmo_q     <= '0;
      dac_val_q <= '0;
      dac_req_q <= '0;
      err_q     <= 1'b0;
      upd_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      rcnt_q <= rcnt_d;
      // A timeout below overrides this clear when both land in one cycle.
      if (clr_err_i) err_q <= 1'b0;
      case (state_q)
        IDLE: if (pend_q != 8'h00) state_q <= LOAD;
        LOAD: begin
          for (int k = 0; k < 8; k++) begin
            if (pend_q[k]) dac_val_q[k*DATA_W +: DATA_W] <= shadow_q[k];
          end
          dac_req_q <= pend_q;
          tmo_q     <= '0;
          state_q   <= REQ;
        end
        REQ: begin
          if (dac.dac_ack) begin
            dac_req_q <= '0;
            tmo_q     <= '0;
            state_q   <= REL;
          end else if (tmo_hit) begin
            err_q     <= 1'b1;
            dac_req_q <= '0;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        REL: begin
          if (!dac.dac_ack) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            state_q   <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac.dac_val   = dac_val_q;
  assign dac.dac_req   = dac_req_q;
  assign busy_o        = (state_q != IDLE) || (pend_q != 8'h00);
  assign err_timeout_o = err_q;
  assign upd_cnt_o     = upd_cnt_q;

endmodule

// File: tb/tb_dac_cmd_sched.sv
// Scoreboard bench for dac_cmd_sched: expected (mask, dac_val) pairs are queued
// at commit time and compared when each request rises.
module tb_dac_cmd_sched;
  localparam int DW = 14;

  typedef struct {
    logic [7:0]      mask;
    logic [8*DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [2:0]    wr_ch;
  logic [DW-1:0] wr_data;
  logic          commit;
  logic [7:0]    commit_mask;
  logic [31:0]   refresh_time;
  logic          clr_err;
  logic          busy, err_timeout;
  logic [31:0]   upd_cnt;

  dac_cmd_sched_if #(.DATA_W(DW)) dac_if ();

  dac_cmd_sched #(.DATA_W(DW), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
    .commit_i(commit), .commit_mask_i(commit_mask), .reg_refresh_time_i(refresh_time),
    .clr_err_i(clr_err), .dac(dac_if), .busy_o(busy), .err_timeout_o(err_timeout),
    .upd_cnt_o(upd_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc = 0, fall_cyc = 0, done_cyc = 0, last_commit_cyc = 0;
  int hs_seen = 0;
  int ack_dly = 0;
  int n0;
  bit ack_auto, chk_gap;
  logic [7:0]      prev_req = '0;
  logic [31:0]     prev_upd = '0;
  logic [DW-1:0]   m_shadow [8];
  logic [8*DW-1:0] m_val;
  exp_t            sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] m);
    exp_t e;
    for (int k = 0; k < 8; k++) if (m[k]) m_val[k*DW +: DW] = m_shadow[k];
    e.mask = m;
    e.val  = m_val;
    sb.push_back(e);
  endtask

  task automatic wr(input int ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_data = d;
    m_shadow[ch] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic send_commit(input logic [7:0] m);
    commit = 1'b1; commit_mask = m;
    step();
    last_commit_cyc = cyc;
    commit = 1'b0; commit_mask = '0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (dac_if.dac_req == 8'h00 && n < budget) begin step(); n++; end
    check("wait_req", dac_if.dac_req != 8'h00, 1'b1);
  endtask

  task automatic wait_fall(input int budget);
    int n = 0;
    while (dac_if.dac_req != 8'h00 && n < budget) begin step(); n++; end
    check("wait_fall", dac_if.dac_req == 8'h00, 1'b1);
  endtask

  task automatic wait_upd(input logic [31:0] target, input int budget);
    int n = 0;
    while (upd_cnt != target && n < budget) begin step(); n++; end
    check("upd_cnt", upd_cnt, target);
  endtask

  // Handshake partner: ack 3 cycles after req appears, release 2 after it drops.
  initial begin
    dac_if.dac_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !ack_auto) begin
        dac_if.dac_ack = 1'b0; ack_dly = 0;
      end else if (!dac_if.dac_ack) begin
        if (dac_if.dac_req != 8'h00) begin
          ack_dly++;
          if (ack_dly == 3) begin dac_if.dac_ack = 1'b1; ack_dly = 0; end
        end
      end else if (dac_if.dac_req == 8'h00) begin
        ack_dly++;
        if (ack_dly == 2) begin dac_if.dac_ack = 1'b0; ack_dly = 0; end
      end
    end
  end

  // Monitor: scoreboard pop on each request rise, edge timestamps.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = '0; prev_upd = '0;
    end else begin
      if (dac_if.dac_req != 8'h00 && prev_req == 8'h00) begin
        rise_cyc = cyc;
        hs_seen++;
        if (sb.size() == 0) begin
          check("unexpected_req", dac_if.dac_req, 8'h00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("req_mask", dac_if.dac_req, e.mask);
          check("dac_val", dac_if.dac_val, e.val);
        end
        if (chk_gap) check("refresh_gap", rise_cyc - done_cyc, 102);
      end
      if (dac_if.dac_req == 8'h00 && prev_req != 8'h00) fall_cyc = cyc;
      if (upd_cnt != prev_upd) done_cyc = cyc;
      prev_req = dac_if.dac_req;
      prev_upd = upd_cnt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 0; wr_ch = 0; wr_data = 0; commit = 0; commit_mask = 0;
    refresh_time = 0; clr_err = 0; ack_auto = 1; chk_gap = 0;
    for (int k = 0; k < 8; k++) m_shadow[k] = '0;
    m_val = '0;
    repeat (3) step();
    check("rst_req", dac_if.dac_req, 8'h00);
    check("rst_val", dac_if.dac_val, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_upd", upd_cnt, 0);
    rst = 1'b0;
    repeat (2) step();

    // Single update with latency check.
    wr(0, 14'h0123);
    push_exp(8'h01);
    send_commit(8'h01);
    check("busy_after_commit", busy, 1'b1);
    wait_req(10);
    check("req_latency", rise_cyc - last_commit_cyc, 2);
    wait_upd(1, 30);
    check("busy_after_done", busy, 1'b0);

    // Serialise and merge.
    for (int k = 1; k < 6; k++) wr(k, DW'(14'h0111 * k));
    push_exp(8'h0F);
    send_commit(8'h0F);
    wait_req(10);
    send_commit(8'h10);
    send_commit(8'h20);
    push_exp(8'h30);
    wait_upd(3, 60);
    check("ch67_untouched", dac_if.dac_val[8*DW-1:6*DW], 0);

    // Write/commit collision, then a write while frozen.
    wr(5, 14'h0AAA);
    push_exp(8'h20);
    send_commit(8'h20);
    wait_upd(4, 30);
    wr_en = 1'b1; wr_ch = 3'd5; wr_data = 14'h3FFF; m_shadow[5] = 14'h3FFF;
    push_exp(8'h20);
    send_commit(8'h20);
    wr_en = 1'b0;
    wait_req(10);
    wr(5, 14'h1111);
    check("ch5_frozen_req", dac_if.dac_val[5*DW +: DW], 14'h3FFF);
    wait_upd(5, 30);
    check("ch5_after_done", dac_if.dac_val[5*DW +: DW], 14'h3FFF);

    // Timeout with ack stuck low.
    ack_auto = 0;
    push_exp(8'h01);
    send_commit(8'h01);
    wait_req(10);
    wait_fall(40);
    check("timeout_cycles", fall_cyc - rise_cyc, 16);
    check("err_set", err_timeout, 1'b1);
    check("upd_after_tmo", upd_cnt, 5);
    step();
    check("busy_after_tmo", busy, 1'b0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("err_cleared", err_timeout, 1'b0);
    ack_auto = 1;

    // Periodic refresh, then disable.
    repeat (3) push_exp(8'hFF);
    refresh_time = 32'd100;
    wait_upd(6, 400);
    chk_gap = 1;
    wait_upd(8, 600);
    chk_gap = 0;
    refresh_time = 32'd0;
    n0 = hs_seen;
    repeat (300) step();
    check("refresh_stopped", hs_seen, n0);
    check("upd_after_refresh", upd_cnt, 8);
    check("busy_refresh_off", busy, 1'b0);

    // Reset in the middle of REQ.
    push_exp(8'h03);
    send_commit(8'h03);
    wait_req(10);
    rst = 1'b1;
    #1;
    check("midrst_req", dac_if.dac_req, 8'h00);
    check("midrst_val", dac_if.dac_val, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_upd", upd_cnt, 0);
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) m_shadow[k] = '0;
    m_val = '0;
    n0 = hs_seen;
    repeat (50) step();
    check("no_req_after_rst", hs_seen, n0);
    check("idle_after_rst", busy, 1'b0);

    // Normal operation resumes with a fresh commit.
    wr(7, 14'h1234);
    push_exp(8'h80);
    send_commit(8'h80);
    wait_upd(1, 30);
    check("ch7_after_rst", dac_if.dac_val[7*DW +: DW], 14'h1234);
    check("ch0_after_rst", dac_if.dac_val[DW-1:0], 14'h0000);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
